// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, redirect/stall inputs, IF/ID outputs.
// master = fetch unit side, slave = memory/pipeline side.
interface fetch_unit_if;
   logic        im_req;
   logic [31:0] im_addr;
   logic        im_ready;
   logic [31:0] im_rdata;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        do_hazard;
   logic [31:0] oIF_instruction;
   logic [31:0] oIF_pc;
   logic        oIF_valid;
   logic        do_flush_REG1;

   modport master (
      output im_req, im_addr, oIF_instruction, oIF_pc, oIF_valid, do_flush_REG1,
      input  im_ready, im_rdata, branch_taken, branch_target, do_hazard
   );

   modport slave (
      input  im_req, im_addr, oIF_instruction, oIF_pc, oIF_valid, do_flush_REG1,
      output im_ready, im_rdata, branch_taken, branch_target, do_hazard
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, 2-entry {instr,pc} FIFO and IDLE/REQ/DROP request FSM; im_ready -> oIF_valid next cycle.
// Backpressure: do_hazard holds the FIFO head; fetching pauses only when both entries are occupied.
module fetch_unit (
   input  logic         clock,
   input  logic         reset_n,
   fetch_unit_if.master bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DROP = 2'd2
   } state_e;

   typedef struct packed {
      logic        vld;
      logic [31:0] instr;
      logic [31:0] pc;
   } entry_t;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] im_addr_q, im_addr_d;
   logic        im_req_q, im_req_d;
   logic        flush_q, flush_d;
   entry_t      e0_q, e0_d;
   entry_t      e1_q, e1_d;

   logic        push;
   logic        pop;
   logic [1:0]  cnt;
   logic [1:0]  cnt_nx;
   entry_t      new_e;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      im_addr_d = im_addr_q;
      im_req_d  = im_req_q;
      flush_d   = bus.branch_taken;
      e0_d      = e0_q;
      e1_d      = e1_q;

      cnt       = {1'b0, e0_q.vld} + {1'b0, e1_q.vld};
      pop       = e0_q.vld && !bus.do_hazard;
      push      = (state_q == ST_REQ) && bus.im_ready;
      cnt_nx    = cnt + {1'b0, push} - {1'b0, pop};
      new_e     = '{vld: 1'b1, instr: bus.im_rdata, pc: pc_q};

      if (bus.branch_taken) begin
         // Redirect wins over everything: any arriving word belongs to the old path.
         e0_d = '0;
         e1_d = '0;
         pc_d = {bus.branch_target[31:2], 2'b00};
         case (state_q)
            ST_REQ: begin
               im_req_d = 1'b1;
               if (bus.im_ready) begin
                  im_addr_d = pc_d;
               end else begin
                  state_d = ST_DROP;
               end
            end
            ST_DROP: begin
               state_d = ST_DROP;
            end
            default: begin
               state_d   = ST_REQ;
               im_req_d  = 1'b1;
               im_addr_d = pc_d;
            end
         endcase
      end else begin
         if (push && pop) begin
            if (e1_q.vld) begin
               e0_d = e1_q;
               e1_d = new_e;
            end else begin
               e0_d = new_e;
            end
         end else if (pop) begin
            e0_d = e1_q;
            e1_d = '0;
         end else if (push) begin
            if (e0_q.vld) begin
               e1_d = new_e;
            end else begin
               e0_d = new_e;
            end
         end

         if (push) begin
            pc_d = pc_q + 32'd4;
         end

         case (state_q)
            ST_IDLE: begin
               if (cnt_nx < 2'd2) begin
                  state_d   = ST_REQ;
                  im_req_d  = 1'b1;
                  im_addr_d = pc_q;
               end
            end
            ST_REQ: begin
               if (push) begin
                  if (cnt_nx < 2'd2) begin
                     im_addr_d = pc_d;
                  end else begin
                     state_d  = ST_IDLE;
                     im_req_d = 1'b0;
                  end
               end
            end
            ST_DROP: begin
               // Stale response consumed; restart at the redirected PC.
               if (bus.im_ready) begin
                  state_d   = ST_REQ;
                  im_req_d  = 1'b1;
                  im_addr_d = pc_q;
               end
            end
            default: begin
               state_d  = ST_IDLE;
               im_req_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         pc_q      <= '0;
         im_addr_q <= '0;
         im_req_q  <= 1'b0;
         flush_q   <= 1'b0;
         e0_q      <= '0;
         e1_q      <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         im_addr_q <= im_addr_d;
         im_req_q  <= im_req_d;
         flush_q   <= flush_d;
         e0_q      <= e0_d;
         e1_q      <= e1_d;
      end
   end

   // Unoccupied entries are kept all-zero, so the head drives the outputs as-is.
   assign bus.im_req          = im_req_q;
   assign bus.im_addr         = im_addr_q;
   assign bus.oIF_valid       = e0_q.vld;
   assign bus.oIF_instruction = e0_q.instr;
   assign bus.oIF_pc          = e0_q.pc;
   assign bus.do_flush_REG1   = flush_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: queue-based fetch model checked every cycle plus literal spot checks.
module tb_fetch_unit;

   logic clock = 1'b0;
   logic reset_n;

   fetch_unit_if ifc();

   fetch_unit dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (ifc)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory answers with a word derived from whatever address is being requested.
   always @* ifc.im_rdata = mem_word(ifc.im_addr);

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } ent_t;

   ent_t        mq[$];
   ent_t        ne;
   logic [31:0] m_pc;
   logic [31:0] stale_addr;
   bit          stale;
   bit          started;
   bit          m_flush;

   // Model: words accepted in address order; a redirect drops queued words and any in-flight reply.
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mq.delete();
         m_pc       = 32'd0;
         stale      = 1'b0;
         stale_addr = 32'd0;
         started    = 1'b0;
         m_flush    = 1'b0;
      end else begin
         m_flush = ifc.branch_taken;
         if (ifc.branch_taken) begin
            if (!stale && ifc.im_req && !ifc.im_ready) begin
               stale      = 1'b1;
               stale_addr = ifc.im_addr;
            end
            mq.delete();
            m_pc = ifc.branch_target & 32'hFFFF_FFFC;
         end else begin
            if (mq.size() > 0 && !ifc.do_hazard) void'(mq.pop_front());
            if (ifc.im_req && ifc.im_ready) begin
               if (stale) begin
                  stale = 1'b0;
               end else begin
                  ne.instr = mem_word(m_pc);
                  ne.pc    = m_pc;
                  mq.push_back(ne);
                  m_pc = m_pc + 32'd4;
               end
            end
         end
         started = 1'b1;
      end
   end

   always @(negedge clock) begin
      if (reset_n) begin
         chk("valid", {31'd0, ifc.oIF_valid}, {31'd0, mq.size() > 0});
         if (mq.size() > 0) begin
            chk("oif_pc", ifc.oIF_pc, mq[0].pc);
            chk("oif_instr", ifc.oIF_instruction, mq[0].instr);
         end else begin
            chk("oif_pc_zero", ifc.oIF_pc, 32'd0);
            chk("oif_instr_zero", ifc.oIF_instruction, 32'd0);
         end
         chk("flush", {31'd0, ifc.do_flush_REG1}, {31'd0, m_flush});
         chk("im_req", {31'd0, ifc.im_req},
             {31'd0, started && (mq.size() < 2 || stale)});
         if (ifc.im_req)
            chk("im_addr", ifc.im_addr, stale ? stale_addr : m_pc);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got no end expected end");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n           = 1'b0;
      ifc.im_ready      = 1'b0;
      ifc.branch_taken  = 1'b0;
      ifc.branch_target = 32'd0;
      ifc.do_hazard     = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_im_req", {31'd0, ifc.im_req}, 32'd0);
      chk("rst_im_addr", ifc.im_addr, 32'd0);
      chk("rst_valid", {31'd0, ifc.oIF_valid}, 32'd0);
      chk("rst_oif_pc", ifc.oIF_pc, 32'd0);
      chk("rst_oif_instr", ifc.oIF_instruction, 32'd0);
      chk("rst_flush", {31'd0, ifc.do_flush_REG1}, 32'd0);

      // Sequential fetch with an always-ready memory.
      @(posedge clock); #1;
      reset_n      = 1'b1;
      ifc.im_ready = 1'b1;
      step(1);
      chk("first_req", {31'd0, ifc.im_req}, 32'd1);
      chk("first_addr", ifc.im_addr, 32'd0);
      step(1);
      chk("first_word_pc", ifc.oIF_pc, 32'd0);
      chk("first_word", ifc.oIF_instruction, 32'hA5A5_0000);
      chk("second_addr", ifc.im_addr, 32'd4);
      step(1);
      chk("second_word_pc", ifc.oIF_pc, 32'd4);
      step(6);
      chk("steady_pc", ifc.oIF_pc, 32'd28);

      // Decode stall: FIFO fills, fetch pauses, head frozen.
      ifc.do_hazard = 1'b1;
      step(5);
      chk("stall_req", {31'd0, ifc.im_req}, 32'd0);
      chk("stall_pc", ifc.oIF_pc, 32'd28);
      ifc.do_hazard = 1'b0;
      step(1);
      chk("resume_pc", ifc.oIF_pc, 32'd32);
      step(4);

      // Redirect with a full FIFO and a stalled decode.
      ifc.do_hazard = 1'b1;
      step(3);
      ifc.branch_taken  = 1'b1;
      ifc.branch_target = 32'h0000_0103;
      step(1);
      ifc.branch_taken = 1'b0;
      ifc.do_hazard    = 1'b0;
      chk("br_flush", {31'd0, ifc.do_flush_REG1}, 32'd1);
      chk("br_valid", {31'd0, ifc.oIF_valid}, 32'd0);
      chk("br_addr", ifc.im_addr, 32'h0000_0100);
      step(1);
      chk("br_flush_off", {31'd0, ifc.do_flush_REG1}, 32'd0);
      chk("br_first_pc", ifc.oIF_pc, 32'h0000_0100);
      step(2);

      // Redirect during an outstanding request, then a second redirect while dropping.
      ifc.im_ready = 1'b0;
      step(2);
      ifc.branch_taken  = 1'b1;
      ifc.branch_target = 32'h0000_0200;
      step(1);
      ifc.branch_taken = 1'b0;
      chk("drop_flush", {31'd0, ifc.do_flush_REG1}, 32'd1);
      step(1);
      ifc.branch_taken  = 1'b1;
      ifc.branch_target = 32'h0000_0302;
      step(1);
      ifc.branch_taken = 1'b0;
      step(1);
      ifc.im_ready = 1'b1;
      step(1);
      chk("drop_valid", {31'd0, ifc.oIF_valid}, 32'd0);
      chk("drop_new_addr", ifc.im_addr, 32'h0000_0300);
      step(1);
      chk("drop_first_pc", ifc.oIF_pc, 32'h0000_0300);
      step(2);

      // Address wrap at the top of the space.
      ifc.branch_taken  = 1'b1;
      ifc.branch_target = 32'hFFFF_FFFF;
      step(1);
      ifc.branch_taken = 1'b0;
      chk("wrap_req_addr", ifc.im_addr, 32'hFFFF_FFFC);
      step(1);
      chk("wrap_next_addr", ifc.im_addr, 32'd0);
      chk("wrap_head_pc", ifc.oIF_pc, 32'hFFFF_FFFC);
      step(3);

      // Reset in the middle of a request; a reply during reset must be ignored.
      ifc.im_ready = 1'b0;
      step(1);
      reset_n = 1'b0;
      #1;
      chk("midrst_req", {31'd0, ifc.im_req}, 32'd0);
      chk("midrst_valid", {31'd0, ifc.oIF_valid}, 32'd0);
      ifc.im_ready = 1'b1;
      step(2);
      chk("midrst_ignored", {31'd0, ifc.oIF_valid}, 32'd0);
      ifc.im_ready = 1'b0;
      @(posedge clock); #1;
      reset_n = 1'b1;
      step(1);
      chk("restart_req", {31'd0, ifc.im_req}, 32'd1);
      chk("restart_addr", ifc.im_addr, 32'd0);
      ifc.im_ready = 1'b1;
      step(1);
      chk("restart_word_pc", ifc.oIF_pc, 32'd0);
      chk("restart_word", ifc.oIF_instruction, 32'hA5A5_0000);
      step(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 im_req  output  1  instruction-memory read request; held until im_ready.
REQ-005 im_addr  output  32  word-aligned fetch address; stable while im_req=1.
REQ-006 im_ready  input  1  im_rdata valid this cycle; completes the current request.
REQ-007 im_rdata  input  32  fetched instruction word.
REQ-008 branch_taken  input  1  one-cycle redirect pulse from the execute stage.
REQ-009 branch_target  input  32  redirect address; bits [1:0] ignored.
REQ-010 do_hazard  input  1  decode stall; the output instruction is not consumed.
REQ-011 oIF_instruction  output  32  instruction to the IF/ID wall; 32'b0 when oIF_valid=0.
REQ-012 oIF_pc  output  32  address of oIF_instruction; 32'b0 when oIF_valid=0.
REQ-013 oIF_valid  output  1  oIF_instruction holds a real fetched word.
REQ-014 do_flush_REG1  output  1  registered one-cycle pulse; IF/ID wall loads a bubble.

Function
REQ-015 The block SHALL hold a 32-bit fetch PC, a 2-entry instruction FIFO with {instruction, pc} per entry, and a 3-state FSM: IDLE, REQ, DROP.
REQ-016 In IDLE, im_req SHALL be 0; the FSM SHALL go to REQ when the FIFO count is below 2.
REQ-017 In REQ, im_req SHALL be 1 and im_addr SHALL equal the fetch PC.
REQ-018 In REQ with im_ready=1, the block SHALL push {im_rdata, PC} and add 4 to the PC (wrap 32'hFFFFFFFC -> 0).
REQ-019 In REQ with im_ready=1, the FSM SHALL stay in REQ if the post-push/pop count is below 2, else go to IDLE.
REQ-020 Pop rule: when oIF_valid=1 and do_hazard=0, the head entry SHALL be popped at the clock edge.
REQ-021 A same-cycle push and pop SHALL both occur; the count SHALL be unchanged.
REQ-022 A push SHALL never occur with count=2, so no overflow is possible; the FSM guarantees this.
REQ-023 oIF_instruction, oIF_pc and oIF_valid SHALL be driven directly from the FIFO head register.
REQ-024 Latency SHALL be: im_ready high at edge N -> oIF_valid=1 after edge N when the FIFO was empty.
REQ-025 branch_taken=1 at an edge SHALL empty the FIFO and load PC <= {branch_target[31:2],2'b00}.
REQ-026 branch_taken=1 at an edge SHALL set do_flush_REG1=1 for exactly the following cycle.
REQ-027 On a branch in REQ with im_ready=0, the FSM SHALL enter DROP.
REQ-028 In DROP, im_req SHALL stay 1 with the old im_addr held in a separate register; the response SHALL be discarded, after which the FSM goes to REQ at the new PC.
REQ-029 On a branch in REQ with im_ready=1, or in IDLE, the response SHALL be discarded and the FSM SHALL go to REQ at the new PC.
REQ-030 A branch in DROP SHALL update the PC only; the FSM SHALL remain in DROP.
REQ-031 branch_taken SHALL take priority over do_hazard and over any same-cycle push or pop.
REQ-032 do_hazard SHALL NOT stop fetching while FIFO space remains.

Reset
REQ-033 While reset_n=0, outputs SHALL be: PC=0, FIFO empty, FSM=IDLE, im_req=0, im_addr=0, oIF_*=0, do_flush_REG1=0.
REQ-034 Assertion of reset_n mid-request SHALL abandon the request; a later im_ready SHALL be ignored in IDLE.
REQ-035 Deassertion of reset_n SHALL give im_req=1, im_addr=0 within one cycle.

Verification
REQ-036 Reset release, im_ready always 1 -> im_addr 0,4,8,...; oIF_pc 0,4,8 on consecutive cycles; words in order.
REQ-037 do_hazard held 5 cycles, memory always ready -> FIFO fills to 2, im_req=0, oIF_pc frozen; on release, fetch order resumes with no gaps or duplicates.
REQ-038 branch_taken with target 32'h0000_0103 while the FIFO holds 2 -> do_flush_REG1 pulses once, oIF_valid=0, next im_addr=32'h100.
REQ-039 Branch while a request is outstanding with im_ready delayed 3 cycles -> DROP state; the old word is never output; the next im_addr is the target.
REQ-040 PC=32'hFFFF_FFFC fetched -> the next im_addr is 0.
REQ-041 Reset asserted mid-REQ, then im_ready pulsed -> no push; after release, fetching restarts at 0.
